// File: rtl/otter_intr_ctrl.sv
// OTTER MMIO interrupt controller: per-source enable, edge/level mode,
// fixed priority, claim/EOI. Optional input synchroniser: OTTER_INTR_SYNC_EN.
module otter_intr_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC,
  input  logic [31:0]        IO_ADDR,
  input  logic [31:0]        IO_WDATA,
  input  logic               IO_WR,
  output logic [31:0]        RD_DATA,
  input  logic               INT_ACK,
  output logic               INTR,
  output logic [4:0]         INT_ID
);

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] edge_pend;
  logic [NUM_SRC-1:0] edge_next;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] mode_next;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] wdata;
  logic [4:0]         winner;
  logic [4:0]         off;
  logic               in_win;
  logic               sel_pend;
  logic               sel_en;
  logic               sel_mode;
  logic               sel_claim;
  logic               ack_ok;
  logic               eoi;
  logic               in_service;
  logic               intr;
  logic [4:0]         int_id;
  logic               unused_wdata;

`ifdef OTTER_INTR_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SRC;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = SRC;
`endif

  assign unused_wdata = ^IO_WDATA;
  assign wdata = IO_WDATA[NUM_SRC-1:0];

  assign off       = IO_ADDR[4:0];
  assign in_win    = IO_ADDR[31:5] == BASE_ADDR[31:5];
  assign sel_pend  = in_win && off == 5'h00;
  assign sel_en    = in_win && off == 5'h04;
  assign sel_mode  = in_win && off == 5'h08;
  assign sel_claim = in_win && off == 5'h0C;

  assign pending = (mode & edge_pend) | (~mode & s);
  assign req     = pending & enable;
  assign ack_ok  = INT_ACK & intr;
  assign eoi     = IO_WR & sel_claim;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[i]) winner = 5'(i);
  end

  // Edge bits survive only while the (new) mode is edge; set beats clear.
  always_comb begin
    clr = (IO_WR && sel_pend) ? wdata : '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (ack_ok && winner == 5'(i)) clr[i] = 1'b1;
    mode_next = (IO_WR && sel_mode) ? wdata : mode;
    edge_next = mode_next & ((s & ~prev) | (edge_pend & ~clr));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev       <= '0;
      edge_pend  <= '0;
      enable     <= '0;
      mode       <= '0;
      in_service <= 1'b0;
      intr       <= 1'b0;
      int_id     <= '0;
    end else begin
      prev      <= s;
      edge_pend <= edge_next;
      mode      <= mode_next;
      if (IO_WR && sel_en) enable <= wdata;
      intr <= (|req) & ~in_service & ~INT_ACK;
      if (ack_ok) begin
        in_service <= 1'b1;
        int_id     <= winner;
      end else if (eoi) begin
        in_service <= 1'b0;
      end
    end
  end

  always_comb begin
    RD_DATA = '0;
    unique case (1'b1)
      sel_pend:  RD_DATA[NUM_SRC-1:0] = pending;
      sel_en:    RD_DATA[NUM_SRC-1:0] = enable;
      sel_mode:  RD_DATA[NUM_SRC-1:0] = mode;
      sel_claim: RD_DATA = {in_service, 26'b0, int_id};
      default:   RD_DATA = '0;
    endcase
  end

  assign INTR   = intr;
  assign INT_ID = int_id;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed self-checking bench for otter_intr_ctrl.
// Latency adapts to OTTER_INTR_SYNC_EN.
module tb_otter_intr_ctrl;

  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] A_PND = BASE + 32'h00;
  localparam logic [31:0] A_EN  = BASE + 32'h04;
  localparam logic [31:0] A_MD  = BASE + 32'h08;
  localparam logic [31:0] A_CLM = BASE + 32'h0C;
`ifdef OTTER_INTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  SRC;
  logic [31:0] IO_ADDR;
  logic [31:0] IO_WDATA;
  logic        IO_WR;
  logic [31:0] RD_DATA;
  logic        INT_ACK;
  logic        INTR;
  logic [4:0]  INT_ID;

  int tests = 0;
  int fails = 0;

  otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .SRC(SRC),
    .IO_ADDR(IO_ADDR), .IO_WDATA(IO_WDATA), .IO_WR(IO_WR),
    .RD_DATA(RD_DATA), .INT_ACK(INT_ACK), .INTR(INTR), .INT_ID(INT_ID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_lat();
    repeat (LAT) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp);
    IO_ADDR = addr;
    #1;
    chk(tag, RD_DATA, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    IO_ADDR  = addr;
    IO_WDATA = data;
    IO_WR    = 1'b1;
    tick();
    IO_WR    = 1'b0;
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    SRC = v;
    tick();
    SRC = '0;
    wait_lat();
  endtask

  initial begin
    RESET = 1'b1; SRC = '0; IO_ADDR = '0; IO_WDATA = '0;
    IO_WR = 1'b0; INT_ACK = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    chk("rst_intr", {31'b0, INTR}, 32'h0);
    chk("rst_id", {27'b0, INT_ID}, 32'h0);
    chk_rd("rst_claim", A_CLM, 32'h0);
    chk_rd("rst_en", A_EN, 32'h0);
    chk_rd("rst_mode", A_MD, 32'h0);
    chk_rd("rst_pend", A_PND, 32'h0);

    // single edge source, basic claim
    wr(A_EN, 32'h01);
    wr(A_MD, 32'h01);
    pulse(8'h01);
    chk("s1_intr_k", {31'b0, INTR}, 32'h0);
    chk_rd("s1_pend", A_PND, 32'h1);
    tick();
    chk("s1_intr_k1", {31'b0, INTR}, 32'h1);
    ack();
    chk("s1_intr_ack", {31'b0, INTR}, 32'h0);
    chk("s1_id", {27'b0, INT_ID}, 32'h0);
    chk_rd("s1_claim", A_CLM, 32'h8000_0000);
    chk_rd("s1_pend0", A_PND, 32'h0);
    wr(A_CLM, 32'h0);
    chk_rd("s1_eoi", A_CLM, 32'h0);
    tick();
    chk("s1_idle", {31'b0, INTR}, 32'h0);

    // priority: 2 beats 5
    wr(A_MD, 32'h24);
    wr(A_EN, 32'h24);
    pulse(8'h24);
    chk_rd("s2_pend", A_PND, 32'h24);
    tick();
    chk("s2_intr", {31'b0, INTR}, 32'h1);
    ack();
    chk("s2_id2", {27'b0, INT_ID}, 32'h2);
    chk_rd("s2_pend20", A_PND, 32'h20);
    wr(A_CLM, 32'h0);
    chk("s2_eoi_low", {31'b0, INTR}, 32'h0);
    tick();
    chk("s2_reassert", {31'b0, INTR}, 32'h1);
    ack();
    chk("s2_id5", {27'b0, INT_ID}, 32'h5);
    chk_rd("s2_pend0", A_PND, 32'h0);
    wr(A_CLM, 32'h0);
    tick();
    chk("s2_idle", {31'b0, INTR}, 32'h0);

    // level source 3
    wr(A_MD, 32'h0);
    wr(A_EN, 32'h08);
    SRC = 8'h08;
    tick();
    wait_lat();
    chk("s3_intr", {31'b0, INTR}, 32'h1);
    chk_rd("s3_pend", A_PND, 32'h08);
    ack();
    chk("s3_id", {27'b0, INT_ID}, 32'h3);
    chk("s3_ack_low", {31'b0, INTR}, 32'h0);
    wr(A_CLM, 32'h0);
    chk("s3_eoi_low", {31'b0, INTR}, 32'h0);
    tick();
    chk("s3_reassert", {31'b0, INTR}, 32'h1);
    ack();
    SRC = '0;
    wait_lat();
    wr(A_CLM, 32'h0);
    tick();
    chk("s3_drop_a", {31'b0, INTR}, 32'h0);
    tick();
    chk("s3_drop_b", {31'b0, INTR}, 32'h0);

    // masked pending, W1C, window decode
    wr(A_EN, 32'h0);
    wr(A_MD, 32'h02);
    pulse(8'h02);
    tick();
    chk("s4_masked", {31'b0, INTR}, 32'h0);
    chk_rd("s4_pend", A_PND, 32'h02);
    wr(A_PND, 32'h02);
    chk_rd("s4_w1c", A_PND, 32'h0);
    wr(A_EN, 32'h02);
    tick();
    chk("s4_en_nopend", {31'b0, INTR}, 32'h0);
    wr(BASE + 32'h24, 32'hFF);
    chk_rd("s4_en_kept", A_EN, 32'h02);
    chk_rd("s4_outside", BASE + 32'h24, 32'h0);
    chk_rd("s4_hole", BASE + 32'h10, 32'h0);

    // ACK and EOI together, ignored ACK
    pulse(8'h02);
    tick();
    chk("s5_intr", {31'b0, INTR}, 32'h1);
    IO_ADDR = A_CLM; IO_WDATA = '0; IO_WR = 1'b1; INT_ACK = 1'b1;
    tick();
    IO_WR = 1'b0; INT_ACK = 1'b0;
    chk_rd("s5_ack_wins", A_CLM, 32'h8000_0001);
    wr(A_CLM, 32'h0);
    chk_rd("s5_eoi", A_CLM, 32'h0000_0001);
    ack();
    chk_rd("s5_ack_ign", A_CLM, 32'h0000_0001);
    chk("s5_ack_ign_i", {31'b0, INTR}, 32'h0);

    // reset mid-service
    wr(A_EN, 32'hFF);
    pulse(8'h02);
    tick();
    ack();
    chk_rd("s6_insvc", A_CLM, 32'h8000_0001);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_rd("s6_claim", A_CLM, 32'h0);
    chk_rd("s6_en", A_EN, 32'h0);
    chk_rd("s6_mode", A_MD, 32'h0);
    chk_rd("s6_pend", A_PND, 32'h0);
    chk("s6_intr", {31'b0, INTR}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
# otter_intr_ctrl

Parametrised, memory-mapped interrupt controller for the OTTER MCU, replacing the single-line `prev_INT` latch with NUM_SRC independently enabled sources. It has per-source edge or level mode, fixed priority, and a claim/EOI handshake. It sits on the MMIO bus (IOBUS_ADDR / IOBUS_OUT / IOBUS_WR), drives the CPU's INTR input, and takes the control unit's interrupt-taken pulse as acknowledge.

## Interface
Parameters:
- NUM_SRC, 8: number of interrupt sources, legal range 1..32.
- BASE_ADDR, 32'h1100_0100: MMIO window base. Must be 32-byte aligned; the window is 32 bytes.

Ports:
- CLK  in  1  system clock. One clock only; everything is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- SRC  in  NUM_SRC  raw interrupt request lines.
- IO_ADDR  in  32  MMIO address (IOBUS_ADDR).
- IO_WDATA  in  32  MMIO write data (IOBUS_OUT).
- IO_WR  in  1  MMIO write strobe (IOBUS_WR).
- RD_DATA  out  32  MMIO read data, combinational from IO_ADDR. Muxed onto IOBUS_IN.
- INT_ACK  in  1  one-cycle pulse from the CU when the interrupt is taken (intTaken).
- INTR  out  1  registered interrupt request to the CPU.
- INT_ID  out  5  ID of the source most recently claimed.

## Operation
Register map (offset from BASE_ADDR; only bits [NUM_SRC-1:0] exist, all higher bits read 0):
- 0x00 PENDING: read-only view of the pending bits. Writing 1 to a bit clears an edge-mode pending bit; a level-mode bit is unaffected by writes.
- 0x04 ENABLE: read/write, reset 0.
- 0x08 MODE: read/write, reset 0. 1 = rising-edge mode, 0 = level mode.
- 0x0C CLAIM: read returns {in_service at bit 31, 26'b0, INT_ID}. Any write is an EOI and clears in_service.
- Other offsets in the window: read 0, writes ignored.
- Addresses outside the window: RD_DATA = 0, writes ignored.

Pending rules:
- Level source: pending[i] = s[i], where s is the conditioned SRC (see Configuration). No storage.
- Edge source: pending[i] sets when s[i] = 1 and prev[i] = 0. It clears on a W1C write, or on INT_ACK when i is the claimed ID.
- A set and a clear in the same cycle: set wins.
- Changing MODE from edge to level discards the stored edge bit.

Selection and handshake:
- req = pending & ENABLE. The winner is the lowest set index of req.
- INTR <= |req & ~in_service & ~INT_ACK.
- INT_ACK while INTR = 1:
  - INT_ID <= winner, in_service <= 1.
  - If the winner is edge-mode, its pending bit is cleared.
  - The winner is the one evaluated in the INT_ACK cycle.
- INT_ACK while INTR = 0: ignored, no state change.
- While in_service = 1, INTR stays 0 regardless of req. Nesting is not supported.
- An EOI write in the same cycle as an accepted INT_ACK: the ACK wins and in_service ends at 1.
- An EOI while in_service = 0: no effect.
- Level sources must be deasserted by the ISR before EOI, otherwise INTR reasserts.

## Timing
- Reset values:
  - INTR = 0, INT_ID = 0, in_service = 0.
  - ENABLE = 0, MODE = 0.
  - Edge pending bits = 0, prev = 0.
  - Synchroniser flops (if present) = 0.
  - RD_DATA is combinational and shows reset contents.
- Latency with the macro off:
  - SRC rising, sampled at edge k: an edge-mode pending bit is set after edge k.
  - INTR rises after edge k+1.
- Latency with the macro on: add 2 cycles.
- Register writes take effect after the clock edge on which IO_WR is sampled. A read in the same cycle shows the old value.
- INTR falls on the edge that samples INT_ACK, i.e. it is low in the following cycle.
- An ENABLE change reaches INTR on the next edge.
- RESET asserted mid-service clears everything on that edge. SRC high across reset is re-detected as an edge only after it goes low and high again, because prev is reset to 0 and then samples 1 at the first post-reset edge.

## Configuration
- OTTER_INTR_SYNC_EN defined: each SRC bit passes through a 2-flop synchroniser before edge and level logic, so s = SRC delayed 2 cycles. Asynchronous external pins may be connected.
- OTTER_INTR_SYNC_EN undefined: s = SRC directly. SRC must be synchronous to CLK.

## Test plan
- Reset, then ENABLE = 0x01, MODE = 0x01, then pulse SRC[0] high for 1 cycle -> INTR = 1 two edges later (macro off). INT_ACK -> INTR = 0 next cycle, INT_ID = 0, CLAIM reads 0x8000_0000, PENDING reads 0.
- SRC[5] and SRC[2] edge-mode, both enabled, both pulse in the same cycle -> first claim gives INT_ID = 2. After EOI (write CLAIM) -> INTR reasserts and the second claim gives INT_ID = 5.
- Level source 3 held high, enabled, claimed, EOI written while still high -> INTR reasserts 1 cycle after EOI. Drop SRC[3] before EOI -> INTR stays 0.
- Edge pending on source 1 with ENABLE = 0 -> INTR stays 0, PENDING reads 0x02. Write PENDING = 0x02 -> reads 0. Write ENABLE = 0x02 -> INTR stays 0.
- INT_ACK and an EOI write in the same cycle with INTR = 1 -> CLAIM bit 31 = 1 afterwards. INT_ACK with INTR = 0 -> no change.
- RESET asserted while in_service = 1 and ENABLE = 0xFF -> next cycle all registers read 0, INTR = 0. With the macro on, repeat the first scenario -> INTR rises 4 edges after the SRC sample.
